// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register addresses,
// serializer state encodings and the store byte-lane helper.
package uart_tx_mmio_pkg;

    localparam logic        ENABLE  = 1'b1;
    localparam logic        DISABLE = 1'b0;

    localparam logic [31:0] UART_ADDR_DEFAULT   = 32'hF6FF_F070;
    localparam logic [31:0] UART_STATUS_OFFSET  = 32'd4;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_START = 2'd1;
    localparam logic [1:0]  ST_DATA  = 2'd2;
    localparam logic [1:0]  ST_STOP  = 2'd3;

    function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
        return data[8*lane +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the head entry (show-ahead).
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter fed by aligned CPU stores through a TX FIFO.
// Optional status read port is built when UART_STATUS_EN is defined.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 60000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] UART_ADDR  = UART_ADDR_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           is_store,
    input  logic [31:0]                    addr,
    input  logic [3:0]                     we,
    input  logic [31:0]                    w_data,
`ifdef UART_STATUS_EN
    input  logic                           is_load,
    output logic [31:0]                    r_data,
`endif
    output logic                           stall,
    output logic                           uart_tx,
    output logic                           tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    logic       hit;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] head;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    assign hit   = (is_store == ENABLE) && (addr[31:2] == UART_ADDR[31:2]) && (we != 4'b0000);
    assign push  = hit && !full;
    assign stall = hit && full;
    assign pop   = (state == ST_IDLE) && !empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (lane_byte(w_data, addr[1:0])),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        shift    <= head;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Line level decoded from state so an async reset forces idle-high at once.
    always_comb begin
        uart_tx = 1'b1;
        case (state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    assign tx_busy = (state != ST_IDLE) || !empty;

`ifdef UART_STATUS_EN
    localparam logic [31:0] UART_STATUS_ADDR = UART_ADDR + UART_STATUS_OFFSET;

    always_comb begin
        r_data = '0;
        if (is_load && (addr[31:2] == UART_STATUS_ADDR[31:2])) begin
            r_data = {30'b0, full, tx_busy};
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: table of single stores plus back-to-back and
// mid-frame reset sequences, with the received serial stream decoded per cycle.
module tb_uart_tx_mmio;

    localparam int unsigned CLK_FREQ   = 1000000;
    localparam int unsigned BAUD       = 100000;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        is_store;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] w_data;
    logic        stall;
    logic        uart_tx;
    logic        tx_busy;
    logic [2:0]  fifo_count;
`ifdef UART_STATUS_EN
    logic        is_load;
    logic [31:0] r_data;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx_mmio #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .UART_ADDR  (32'hF6FF_F070)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .is_store   (is_store),
        .addr       (addr),
        .we         (we),
        .w_data     (w_data),
`ifdef UART_STATUS_EN
        .is_load    (is_load),
        .r_data     (r_data),
`endif
        .stall      (stall),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic        exp_push;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Waits for a start bit, then samples all 100 cycles of the frame at negedges.
    task automatic rx_frame(output logic [7:0] b, output int idle,
                            output logic shape_ok, output logic found);
        logic bits [100];
        logic ev;
        found    = 1'b0;
        idle     = 0;
        b        = '0;
        shape_ok = 1'b1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) found = 1'b1;
            else idle++;
        end
        if (found) begin
            bits[0] = 1'b0;
            for (int s = 1; s < 100; s++) begin
                @(negedge clk);
                bits[s] = uart_tx;
            end
            for (int s = 0; s < 100; s++) begin
                if (s < 10)       ev = 1'b0;
                else if (s >= 90) ev = 1'b1;
                else              ev = bits[(s / 10) * 10];
                if (bits[s] !== ev) shape_ok = 1'b0;
            end
            for (int g = 1; g <= 8; g++) b[g-1] = bits[g * 10];
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         idle;
        logic       ok;
        logic       found;
        logic       low_seen;

        vecs[0] = '{"lane0_55",  1'b1, 32'hF6FF_F070, 4'b0001, 32'h0000_0055, 1'b1, 8'h55};
        vecs[1] = '{"lane3_A5",  1'b1, 32'hF6FF_F073, 4'b1000, 32'hA500_0000, 1'b1, 8'hA5};
        vecs[2] = '{"lane1_C3",  1'b1, 32'hF6FF_F071, 4'b0010, 32'h1200_C334, 1'b1, 8'hC3};
        vecs[3] = '{"lane2_3C",  1'b1, 32'hF6FF_F072, 4'b0100, 32'h993C_7766, 1'b1, 8'h3C};
        vecs[4] = '{"miss_074",  1'b1, 32'hF6FF_F074, 4'b1111, 32'hFFFF_FFFF, 1'b0, 8'h00};
        vecs[5] = '{"miss_06C",  1'b1, 32'hF6FF_F06C, 4'b0001, 32'h0000_0011, 1'b0, 8'h00};
        vecs[6] = '{"no_store",  1'b0, 32'hF6FF_F070, 4'b0001, 32'h0000_0022, 1'b0, 8'h00};
        vecs[7] = '{"we_zero",   1'b1, 32'hF6FF_F070, 4'b0000, 32'h0000_0033, 1'b0, 8'h00};

        rst_n = 1'b0; is_store = 1'b0; addr = '0; we = '0; w_data = '0;
`ifdef UART_STATUS_EN
        is_load = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("idle_uart_tx", 32'(uart_tx), 32'd1);
            chk("idle_busy", 32'(tx_busy), 32'd0);
            chk("idle_count", 32'(fifo_count), 32'd0);
            chk("idle_stall", 32'(stall), 32'd0);
        end

        for (int v = 0; v < 8; v++) begin
            is_store = vecs[v].st; addr = vecs[v].a; we = vecs[v].be; w_data = vecs[v].d;
            #1;
            chk({vecs[v].name, "_stall"}, 32'(stall), 32'd0);
            @(negedge clk);
            chk({vecs[v].name, "_count"}, 32'(fifo_count), 32'(vecs[v].exp_push));
            chk({vecs[v].name, "_busy"}, 32'(tx_busy), 32'(vecs[v].exp_push));
            is_store = 1'b0;
            if (vecs[v].exp_push) begin
                rx_frame(rb, idle, ok, found);
                chk({vecs[v].name, "_found"}, 32'(found), 32'd1);
                chk({vecs[v].name, "_shape"}, 32'(ok), 32'd1);
                chk({vecs[v].name, "_byte"}, 32'(rb), 32'(vecs[v].exp_byte));
                @(negedge clk);
                chk({vecs[v].name, "_busy_after"}, 32'(tx_busy), 32'd0);
            end else begin
                low_seen = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1;
                end
                chk({vecs[v].name, "_line_quiet"}, 32'(low_seen), 32'd0);
            end
            repeat (3) @(negedge clk);
        end

        // Six back-to-back stores with FIFO_DEPTH=4: the sixth is held by stall.
        begin
            int         idx;
            int         stall_cycles;
            logic [2:0] count_at_stall;
            logic       busy_at_stall;
            idx = 0; stall_cycles = 0; count_at_stall = '0; busy_at_stall = 1'b0;
            fork
                begin
                    logic pushed;
                    for (int c = 0; c < 400 && idx < 6; c++) begin
                        is_store = 1'b1; addr = 32'hF6FF_F070; we = 4'b0001;
                        w_data = 32'(idx + 1);
                        #1;
                        pushed = !stall;
                        if (stall) begin
                            if (stall_cycles == 0) begin
                                count_at_stall = fifo_count;
                                busy_at_stall  = tx_busy;
                            end
                            stall_cycles++;
                        end
                        @(negedge clk);
                        if (pushed) idx++;
                    end
                    is_store = 1'b0;
                end
                begin
                    for (int f = 0; f < 6; f++) begin
                        rx_frame(rb, idle, ok, found);
                        chk("b2b_found", 32'(found), 32'd1);
                        chk("b2b_shape", 32'(ok), 32'd1);
                        chk("b2b_byte", 32'(rb), 32'(f + 1));
                        if (f > 0) chk("b2b_gap", 32'(idle), 32'd1);
                    end
                end
            join
            chk("b2b_all_pushed", 32'(idx), 32'd6);
            chk("b2b_stall_seen", 32'(stall_cycles > 0), 32'd1);
            chk("b2b_count_at_stall", 32'(count_at_stall), 32'd4);
            chk("b2b_busy_at_stall", 32'(busy_at_stall), 32'd1);
            low_seen = 1'b0;
            repeat (120) begin
                @(negedge clk);
                if (uart_tx !== 1'b1) low_seen = 1'b1;
            end
            chk("b2b_no_extra_frame", 32'(low_seen), 32'd0);
            chk("b2b_count_end", 32'(fifo_count), 32'd0);
            chk("b2b_busy_end", 32'(tx_busy), 32'd0);
        end

        // Reset asserted in the middle of data bit 3 with a byte still queued.
        is_store = 1'b1; addr = 32'hF6FF_F070; we = 4'b0001; w_data = 32'h00;
        @(negedge clk);
        w_data = 32'hFF;
        @(negedge clk);
        is_store = 1'b0;
        chk("mr_start_low", 32'(uart_tx), 32'd0);
        repeat (45) @(negedge clk);
        chk("mr_bit3_low", 32'(uart_tx), 32'd0);
        chk("mr_count_before", 32'(fifo_count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_uart_tx", 32'(uart_tx), 32'd1);
        chk("mr_count", 32'(fifo_count), 32'd0);
        chk("mr_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        low_seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1;
        end
        chk("mr_no_residual", 32'(low_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
